// File: rtl/pong_link_pkg.sv
// Shared pong board-link definitions: UART FSM states, byte header tags,
// default bit period and the frame byte builder used by tx and rx sides.
package pong_link_pkg;

    // 65 MHz pclk / 115200 baud
    localparam int unsigned CLKS_PER_BIT_DFLT = 564;

    // Header tags: first byte carries ypos[11:6], second ypos[5:0]
    localparam logic [1:0] HDR_HI = 2'b10;
    localparam logic [1:0] HDR_LO = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

    function automatic logic [7:0] frame_byte(
        input logic [11:0] y,
        input logic        sel
    );
        return sel ? {HDR_LO, y[5:0]}
                   : {HDR_HI, y[11:6]};
    endfunction

endpackage

// File: rtl/ypos_uart_tx_if.sv
// Paddle-position link bundle between top_ctl and the UART transmitter.
// master: drives ypos/send, sees tx/busy/done; slave: the transmitter.
interface ypos_uart_tx_if;

    logic [11:0] ypos;
    logic        send;
    logic        tx;
    logic        busy;
    logic        done;

    modport master (
        output ypos,
        output send,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  ypos,
        input  send,
        output tx,
        output busy,
        output done
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: while i_en is high, o_tick marks the last cycle of
// every CLKS_PER_BIT-cycle bit. Ports: clk, rst_n, i_en, o_tick.
module uart_baud_gen
    import pong_link_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DFLT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_tick
);

    localparam int unsigned CNT_W =
        (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_baud_gen: CLKS_PER_BIT must be >= 2");
    end

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == LAST);

    // Held at zero while disabled so every bit starts a full period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_en || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ypos_uart_tx.sv
// Sends the local paddle ypos to the second board as two 8N1 bytes.
// Ports: clk, rst_n, bus (slave: ypos, send -> tx, busy, done).
module ypos_uart_tx
    import pong_link_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DFLT
) (
    input  logic           clk,
    input  logic           rst_n,
    ypos_uart_tx_if.slave  bus
);

    uart_state_e r_state, w_state_nxt;
    logic        r_byte, w_byte_nxt;
    logic [2:0]  r_bit, w_bit_nxt;
    logic [11:0] r_shadow, w_shadow_nxt;
    logic [11:0] r_pend_val, w_pend_val_nxt;
    logic        r_pend, w_pend_nxt;
    logic        r_tx, w_tx_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_done, w_done_nxt;
    logic        w_tick;
    logic        w_pend_any;
    logic [7:0]  w_cur_byte;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (r_state != ST_IDLE),
        .o_tick (w_tick)
    );

    assign w_cur_byte = frame_byte(r_shadow, r_byte);
    // A send arriving on the final stop cycle still counts as pending
    assign w_pend_any = r_pend | bus.send;

    always_comb begin
        w_state_nxt    = r_state;
        w_byte_nxt     = r_byte;
        w_bit_nxt      = r_bit;
        w_shadow_nxt   = r_shadow;
        w_pend_val_nxt = r_pend_val;
        w_pend_nxt     = r_pend;
        w_tx_nxt       = r_tx;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;

        if (bus.send && (r_state != ST_IDLE)) begin
            w_pend_nxt     = 1'b1;
            w_pend_val_nxt = bus.ypos;
        end

        unique case (r_state)
            ST_IDLE: begin
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
                // A fresh send supersedes a queued value
                if (bus.send || r_pend) begin
                    w_shadow_nxt = bus.send ? bus.ypos : r_pend_val;
                    w_pend_nxt   = 1'b0;
                    w_state_nxt  = ST_START;
                    w_byte_nxt   = 1'b0;
                    w_bit_nxt    = 3'd0;
                    w_tx_nxt     = 1'b0;
                    w_busy_nxt   = 1'b1;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt = ST_DATA;
                    w_bit_nxt   = 3'd0;
                    w_tx_nxt    = w_cur_byte[0];
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_bit == 3'd7) begin
                        w_state_nxt = ST_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                        w_tx_nxt  = w_cur_byte[r_bit + 3'd1];
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (!r_byte) begin
                        w_byte_nxt  = 1'b1;
                        w_state_nxt = ST_START;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        // busy held through the idle cycle if more is queued
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                        w_tx_nxt    = 1'b1;
                        w_busy_nxt  = w_pend_any;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_byte     <= 1'b0;
            r_bit      <= 3'd0;
            r_shadow   <= '0;
            r_pend_val <= '0;
            r_pend     <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte     <= w_byte_nxt;
            r_bit      <= w_bit_nxt;
            r_shadow   <= w_shadow_nxt;
            r_pend_val <= w_pend_val_nxt;
            r_pend     <= w_pend_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign bus.tx   = r_tx;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule
